// File: rtl/seg_instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_instruction_fetch_pkg
//  Purpose  : Constants and types shared by the pipeline stages: datapath
//             width, opcode width, HALT opcode, NOP word, fetch FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package seg_instruction_fetch_pkg;

  localparam int unsigned        c_LEN       = 32;
  localparam int unsigned        c_NB_OPCODE = 6;
  localparam logic [5:0]         c_HALT_OP   = 6'b111111;
  localparam logic [c_LEN-1:0]   c_NOP_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/seg_instruction_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_instruction_fetch_if
//  Purpose  : Flow-control, program-loader and IF/ID output bundle of the
//             instruction fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface seg_instruction_fetch_if #(
  parameter int LEN          = 32,
  parameter int NB_IMEM_ADDR = 10
);
  logic                    i_enable;
  logic                    i_stall_flag;
  logic                    i_jump_flag;
  logic [LEN-1:0]          i_PC_dir_jump;
  logic                    i_branch_flag;
  logic [LEN-1:0]          i_PC_branch;
  logic                    i_load_en;
  logic [NB_IMEM_ADDR-1:0] i_load_addr;
  logic [LEN-1:0]          i_load_data;
  logic [LEN-1:0]          o_PC;
  logic [LEN-1:0]          o_instruction;
  logic [LEN-1:0]          o_pc_current;
  logic                    o_halt;

  modport master (
    output i_enable, i_stall_flag, i_jump_flag, i_PC_dir_jump,
           i_branch_flag, i_PC_branch, i_load_en, i_load_addr, i_load_data,
    input  o_PC, o_instruction, o_pc_current, o_halt
  );

  modport slave (
    input  i_enable, i_stall_flag, i_jump_flag, i_PC_dir_jump,
           i_branch_flag, i_PC_branch, i_load_en, i_load_addr, i_load_data,
    output o_PC, o_instruction, o_pc_current, o_halt
  );
endinterface
`default_nettype wire

// File: rtl/seg_instruction_fetch_imem.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_memory
//  Purpose  : Word-addressed instruction store, synchronous write from the
//             program loader, asynchronous read for fetch.
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_memory #(
  parameter int LEN     = 32,
  parameter int NB_ADDR = 10
) (
  input  wire logic               i_clk,
  input  wire logic               i_we,
  input  wire logic [NB_ADDR-1:0] i_waddr,
  input  wire logic [LEN-1:0]     i_wdata,
  input  wire logic [NB_ADDR-1:0] i_raddr,
  output logic      [LEN-1:0]     o_rdata
);

  logic [LEN-1:0] r_mem [2**NB_ADDR];

  // Loader write port; contents are never cleared so reset keeps the image.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/seg_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : seg_instruction_fetch
//  Purpose  : IF stage - PC, IF/ID register and IDLE/RUN/HALT control, with
//             branch > stall > jump > sequential priority.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_instruction_fetch
  import seg_instruction_fetch_pkg::*;
#(
  parameter int                   LEN          = c_LEN,
  parameter int                   NB_IMEM_ADDR = 10,
  parameter int                   NB_OPCODE    = c_NB_OPCODE,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE  = c_HALT_OP
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst,
  seg_instruction_fetch_if.slave bus
);

  fetch_state_t   r_state,    w_state_nxt;
  logic [LEN-1:0] r_pc,       w_pc_nxt;
  logic [LEN-1:0] r_if_pc,    w_if_pc_nxt;
  logic [LEN-1:0] r_if_instr, w_if_instr_nxt;
  logic [LEN-1:0] w_fetch_word;
  logic [LEN-1:0] w_pc_inc;
  logic           w_mem_we;
  logic           w_is_halt;

  // Reset wins over the loader, so a load strobe during reset writes nothing.
  assign w_mem_we  = bus.i_load_en & ~i_rst;
  assign w_pc_inc  = r_pc + LEN'(1);
  assign w_is_halt = (w_fetch_word[LEN-1 -: NB_OPCODE] == HALT_OPCODE);

  instruction_memory #(
    .LEN     (LEN),
    .NB_ADDR (NB_IMEM_ADDR)
  ) u_imem (
    .i_clk   (i_clk),
    .i_we    (w_mem_we),
    .i_waddr (bus.i_load_addr),
    .i_wdata (bus.i_load_data),
    .i_raddr (r_pc[NB_IMEM_ADDR-1:0]),
    .o_rdata (w_fetch_word)
  );

  // State, PC and IF/ID registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_if_pc    <= '0;
      r_if_instr <= c_NOP_WORD;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
    end
  end

  // Next-state and next-register selection; loader activity freezes everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = r_if_instr;
    if (!bus.i_load_en) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_enable) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (bus.i_enable) begin
            if (bus.i_branch_flag) begin
              w_pc_nxt       = bus.i_PC_branch;
              w_if_pc_nxt    = '0;
              w_if_instr_nxt = c_NOP_WORD;
            end else if (bus.i_stall_flag) begin
              w_pc_nxt = r_pc;
            end else if (bus.i_jump_flag) begin
              w_pc_nxt       = bus.i_PC_dir_jump;
              w_if_pc_nxt    = '0;
              w_if_instr_nxt = c_NOP_WORD;
            end else begin
              w_if_pc_nxt    = w_pc_inc;
              w_if_instr_nxt = w_fetch_word;
              // The PC parks on a halt word instead of running past it.
              if (w_is_halt) w_state_nxt = ST_HALT;
              else           w_pc_nxt    = w_pc_inc;
            end
          end
        end
        ST_HALT: begin
          w_if_instr_nxt = c_NOP_WORD;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.o_PC          = r_if_pc;
  assign bus.o_instruction = r_if_instr;
  assign bus.o_pc_current  = r_pc;
  assign bus.o_halt        = (r_state == ST_HALT);

endmodule
`default_nettype wire
